// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data load/store.
// Define MEM_ARB_FETCH_BUF_EN to add a one-entry fetch buffer that bypasses memory on a repeat fetch.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [`XLEN-1:0]      fetch_addr,
    output logic                  fetch_stall,
    output logic [`INSTR_LEN-1:0] instr_out,
    input  logic                  data_re,
    input  logic                  data_we,
    input  logic [`XLEN-1:0]      data_addr,
    input  logic [`XLEN-1:0]      data_wdata,
    output logic                  data_stall,
    output logic [`XLEN-1:0]      read_data_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [`XLEN-1:0]      mem_addr,
    output logic [`XLEN-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [`XLEN-1:0]      mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, BUSY_F, BUSY_D, RESP_F, RESP_D} state_t;

    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic       data_pend;
    logic       grant_f;
    logic       grant_d;
    logic       fetch_hit;

`ifdef MEM_ARB_FETCH_BUF_EN
    logic                  buf_valid;
    logic [`XLEN-1:0]      buf_tag;
    logic [`INSTR_LEN-1:0] buf_data;

    assign fetch_hit = buf_valid && (fetch_addr == buf_tag);
`else
    assign fetch_hit = 1'b0;
`endif

    assign data_pend   = data_re | data_we;
    assign fetch_stall = fetch_req & (state != RESP_F);
    assign data_stall  = data_pend & (state != RESP_D);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Data wins ties unless fetch has been passed over LIMIT times in a row.
    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend && !(fetch_req && starve_cnt == LIMIT)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (fetch_req) begin
                    grant_f   = 1'b1;
                    state_nxt = fetch_hit ? RESP_F : BUSY_F;
                end
            end
            BUSY_F:  if (mem_ack) state_nxt = RESP_F;
            BUSY_D:  if (mem_ack) state_nxt = RESP_D;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            instr_out     <= '0;
            read_data_out <= '0;
            starve_cnt    <= '0;
        end else begin
            if (grant_d) begin
                mem_req  <= 1'b1;
                mem_we   <= data_we;
                mem_addr <= data_addr;
                if (data_we) mem_wdata <= data_wdata;
                if (fetch_req && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
            end else if (grant_f) begin
                starve_cnt <= '0;
                if (!fetch_hit) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= fetch_addr;
                end
`ifdef MEM_ARB_FETCH_BUF_EN
                else begin
                    instr_out <= buf_data;
                end
`endif
            end
            if (state == BUSY_F && mem_ack) begin
                mem_req   <= 1'b0;
                instr_out <= mem_rdata[`INSTR_LEN-1:0];
            end
            if (state == BUSY_D && mem_ack) begin
                mem_req       <= 1'b0;
                read_data_out <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_FETCH_BUF_EN
    // Any store may alias the buffered instruction, so it is dropped on every write grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (state == BUSY_F && mem_ack) begin
            buf_valid <= 1'b1;
            buf_tag   <= mem_addr;
            buf_data  <= mem_rdata[`INSTR_LEN-1:0];
        end else if (grant_d && data_we) begin
            buf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model plus literal checks.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
`ifdef MEM_ARB_FETCH_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_stall;
    logic [31:0] instr_out;
    logic        data_re = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_stall;
    logic [31:0] read_data_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int    checks = 0;
    int    errors = 0;
    bit    cmp_en = 1'b0;
    int    wait_cycles = 0;
    string glog = "";
    logic  prev_req = 1'b0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .instr_out(instr_out),
        .data_re(data_re), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_stall(data_stall), .read_data_out(read_data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory: acks after wait_cycles idle cycles of a held request, abandons on reset.
    int mcnt = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (!reset || !mem_req || mem_ack) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else if (mcnt == wait_cycles) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_read(mem_addr);
        end else begin
            mcnt++;
        end
    end

    // Reference model: one outstanding access (port 0 none, 1 fetch, 2 data) and its response cycle.
    int          m_port = 0;
    bit          m_resp = 1'b0;
    int unsigned m_starve = 0;
    bit          e_req = 1'b0, e_we = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_instr = '0, e_rd = '0;
    bit          bv = 1'b0;
    logic [31:0] btag = '0, bdata = '0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_port = 0; m_resp = 0; m_starve = 0;
            e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_instr = '0; e_rd = '0;
            bv = 0; btag = '0; bdata = '0;
        end else if (m_resp) begin
            m_resp = 0;
            m_port = 0;
        end else if (m_port != 0) begin
            if (mem_ack) begin
                e_req  = 0;
                m_resp = 1;
                if (m_port == 1) begin
                    e_instr = mem_rdata;
                    bv = 1; btag = e_addr; bdata = mem_rdata;
                end else begin
                    e_rd = mem_rdata;
                end
            end
        end else if ((data_re || data_we) && !(fetch_req && m_starve == LIMIT)) begin
            m_port = 2; e_req = 1; e_we = data_we; e_addr = data_addr;
            if (data_we) begin
                e_wdata = data_wdata;
                bv = 0;
            end
            if (fetch_req && m_starve < LIMIT) m_starve++;
        end else if (fetch_req) begin
            m_port = 1;
            m_starve = 0;
            if (BUF && bv && btag == fetch_addr) begin
                m_resp  = 1;
                e_instr = bdata;
            end else begin
                e_req = 1; e_we = 0; e_addr = fetch_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("instr_out", instr_out, e_instr);
            chk("read_data_out", read_data_out, e_rd);
            chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, fetch_req && !(m_resp && m_port == 1)});
            chk("data_stall", {31'b0, data_stall}, {31'b0, (data_re || data_we) && !(m_resp && m_port == 2)});
        end
        if (mem_req && !prev_req) begin
            if (mem_addr == 32'h200) glog = {glog, "F"};
            else                     glog = {glog, "D"};
        end
        prev_req = mem_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rises, highs;
    bit saw_req, done;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_read_data", read_data_out, 32'h0);
        chk("rst_fetch_stall", {31'b0, fetch_stall}, 32'h0);

        // Zero-wait fetch of address 0
        step();
        wait_cycles = 0; fetch_req = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        chk("f0_c0_req", {31'b0, mem_req}, 32'h0);
        chk("f0_c0_stall", {31'b0, fetch_stall}, 32'h1);
        @(negedge clk);
        chk("f0_c1_req", {31'b0, mem_req}, 32'h1);
        chk("f0_c1_stall", {31'b0, fetch_stall}, 32'h1);
        @(negedge clk);
        chk("f0_c2_req", {31'b0, mem_req}, 32'h0);
        chk("f0_c2_instr", instr_out, 32'h0000_0013);
        chk("f0_c2_stall", {31'b0, fetch_stall}, 32'h0);
        step();
        fetch_req = 1'b0;
        repeat (2) step();

        // Store with three wait cycles
        wait_cycles = 3; data_we = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_c0_stall", {31'b0, data_stall}, 32'h1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("st_busy_req", {31'b0, mem_req}, 32'h1);
            chk("st_busy_we", {31'b0, mem_we}, 32'h1);
            chk("st_busy_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_busy_stall", {31'b0, data_stall}, 32'h1);
        end
        @(negedge clk);
        chk("st_c5_stall", {31'b0, data_stall}, 32'h0);
        step();
        data_we = 1'b0;
        repeat (2) step();

        // Continuous load and fetch contention
        wait_cycles = 0; glog = "";
        fetch_req = 1'b1; fetch_addr = 32'h200;
        data_re = 1'b1; data_addr = 32'h300;
        repeat (30) @(negedge clk);
        step();
        fetch_req = 1'b0; data_re = 1'b0;
        checks++;
        if (glog != "DDDDFDDDDF") begin
            errors++;
            $display("FAIL grant_order got %s exp DDDDFDDDDF", glog);
        end
        chk("starve_instr", instr_out, 32'h0200_C0DE);
        chk("starve_rdata", read_data_out, 32'h0300_C0DE);
        repeat (2) step();

        // Fetch withdrawn while in flight
        wait_cycles = 2; fetch_req = 1'b1; fetch_addr = 32'h40;
        @(negedge clk);
        step();
        fetch_req = 1'b0;
        rises = 0; highs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_req) highs++;
            if (mem_req && c == 0) rises++;
            if (c > 0 && mem_req && !prev_req) rises++;
        end
        chk("wd_rises", 32'(rises), 32'd1);
        chk("wd_highs", 32'(highs), 32'd3);
        chk("wd_instr", instr_out, 32'h0040_C0DE);
        step();

        // Reset during a load in flight
        wait_cycles = 3; data_re = 1'b1; data_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("rd_busy_req", {31'b0, mem_req}, 32'h1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mid_rdata", read_data_out, 32'h0);
        chk("rst_mid_stall", {31'b0, data_stall}, 32'h1);
        step();
        reset = 1'b1;
        saw_req = 1'b0; done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h300) saw_req = 1'b1;
            if (!data_stall) done = 1'b1;
        end
        chk("reissue_req", {31'b0, saw_req}, 32'h1);
        chk("reissue_done", {31'b0, done}, 32'h1);
        chk("reissue_rdata", read_data_out, 32'h0300_C0DE);
        step();
        data_re = 1'b0;
        repeat (2) step();

`ifdef MEM_ARB_FETCH_BUF_EN
        // Fetch buffer hit, then invalidation by a store
        wait_cycles = 0; fetch_req = 1'b1; fetch_addr = 32'h40;
        repeat (3) @(negedge clk);
        step();
        fetch_req = 1'b0;
        repeat (2) step();
        fetch_req = 1'b1;
        @(negedge clk);
        chk("hit_c0_stall", {31'b0, fetch_stall}, 32'h1);
        chk("hit_c0_req", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        chk("hit_c1_stall", {31'b0, fetch_stall}, 32'h0);
        chk("hit_c1_req", {31'b0, mem_req}, 32'h0);
        chk("hit_c1_instr", instr_out, 32'h0040_C0DE);
        step();
        fetch_req = 1'b0;
        repeat (2) step();
        data_we = 1'b1; data_addr = 32'h500; data_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        step();
        data_we = 1'b0;
        repeat (2) step();
        fetch_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("inval_req", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        chk("inval_instr", instr_out, 32'h0040_C0DE);
        step();
        fetch_req = 1'b0;
        repeat (2) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
